// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the APB-to-FLL configuration bridge.
package fll_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } fll_cfg_state_e;

    localparam int STATUS_ADDR_BIT = 4;

    localparam int STS_LOCK    = 0;
    localparam int STS_TIMEOUT = 1;

    localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
    localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
    localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
    localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

endpackage

// File: rtl/fll_cfg_sync.sv
// Two-flop synchroniser for one bit, reset to 0; used for ack/lock when FLL_ACK_SYNC_EN is set.
module fll_cfg_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/apb_fll_cfg_master.sv
// APB slave bridging register accesses to the four-phase FLL config port, with timeout watchdog
// and local status register. Define FLL_ACK_SYNC_EN to synchronise fll_ack_i/fll_lock_i.
module apb_fll_cfg_master
    import fll_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      fll_req_o,
    output logic                      fll_wrn_o,
    output logic [1:0]                fll_add_o,
    output logic [31:0]               fll_data_o,
    input  logic                      fll_ack_i,
    input  logic [31:0]               fll_r_data_i,
    input  logic                      fll_lock_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    fll_cfg_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             err_q, err_d;
    logic             wrn_q, wrn_d;
    logic [1:0]       add_q, add_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ack_s;
    logic             lock_s;

`ifdef FLL_ACK_SYNC_EN
    fll_cfg_sync u_ack_sync (.clk_i(clk_i), .rstn_i(rstn_i), .d_i(fll_ack_i),  .q_o(ack_s));
    fll_cfg_sync u_lock_sync(.clk_i(clk_i), .rstn_i(rstn_i), .d_i(fll_lock_i), .q_o(lock_s));
`else
    assign ack_s  = fll_ack_i;
    assign lock_s = fll_lock_i;
`endif

    // penable is deliberately ignored: a transfer starts on psel alone.
    logic unused_inputs;
    assign unused_inputs = ^{paddr_i[APB_ADDR_WIDTH-1:STATUS_ADDR_BIT+1], paddr_i[1:0], penable_i};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            err_q    <= 1'b0;
            wrn_q    <= 1'b1;
            add_q    <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            err_q    <= err_d;
            wrn_q    <= wrn_d;
            add_q    <= add_d;
            data_q   <= data_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        err_d    = err_q;
        wrn_d    = wrn_q;
        add_d    = add_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (psel_i) begin
                    wrn_d   = !pwrite_i;
                    add_d   = paddr_i[3:2];
                    data_d  = pwdata_i;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    if (paddr_i[STATUS_ADDR_BIT]) begin
                        state_d = DONE;
                        if (pwrite_i) begin
                            if (pwdata_i[STS_TIMEOUT]) sticky_d = 1'b0;
                        end else begin
                            rdata_d[STS_LOCK]    = lock_s;
                            rdata_d[STS_TIMEOUT] = sticky_q;
                        end
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = DONE;
                    if (wrn_q) rdata_d = fll_r_data_i;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = DONE;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = IDLE;
                    sticky_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register directly so reset removes req/pready asynchronously.
    assign fll_req_o  = (state_q == REQ);
    assign pready_o   = (state_q == DONE);
    assign pslverr_o  = (state_q == DONE) && err_q;
    assign prdata_o   = (state_q == DONE) ? rdata_q : 32'h0;
    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;

endmodule

// File: tb/tb_apb_fll_cfg_master.sv
// Scoreboard bench for apb_fll_cfg_master: APB transfers against a configurable FLL responder.
`timescale 1ns/1ps
module tb_apb_fll_cfg_master;

    localparam int TO = 8;
`ifdef FLL_ACK_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic        pwrite_i;
    logic        psel_i;
    logic        penable_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i;
    logic [31:0] fll_r_data_i;
    logic        fll_lock_i;

    always #5 clk_i = ~clk_i;

    apb_fll_cfg_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
        .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o),
        .fll_add_o(fll_add_o), .fll_data_o(fll_data_o), .fll_ack_i(fll_ack_i),
        .fll_r_data_i(fll_r_data_i), .fll_lock_i(fll_lock_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  add;
        logic        wrn;
        logic [31:0] data;
        bit          local_acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk_i) cyc++;

    // Responder: 0 = combinational (ack = req), 1 = ack after resp_delay cycles, 2 = ack tied low.
    int   resp_mode = 0;
    int   resp_delay = 5;
    int   resp_cnt = 0;
    logic ack_reg = 1'b0;
    assign fll_ack_i = (resp_mode == 0) ? fll_req_o : ((resp_mode == 1) ? ack_reg : 1'b0);

    always @(posedge clk_i) begin
        #1;
        if (!fll_req_o) begin
            ack_reg  = 1'b0;
            resp_cnt = 0;
        end else if (!ack_reg) begin
            resp_cnt++;
            if (resp_cnt >= resp_delay) ack_reg = 1'b1;
        end
    end

    // Four-phase monitor: a new request must never start while the previous ack is still high.
    bit   mon_en = 1'b0;
    logic req_prev = 1'b0;
    always @(negedge clk_i) begin
        if (mon_en && rstn_i && fll_req_o && !req_prev) begin
            checks++;
            if (fll_ack_i !== 1'b0) begin
                errors++;
                $display("FAIL four_phase: req rose with ack=%b, required ack=0", fll_ack_i);
            end
        end
        req_prev = fll_req_o;
    end

    task automatic apb_xfer(input logic [11:0] addr, input logic [31:0] wdata, input logic wr,
                            input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                            input bit start_now, input bit keep_sel);
        exp_t e;
        exp_t got;
        int   start;
        int   waited;
        bit   seen_req;
        bit   done;
        e.rdata     = (wr || exp_err) ? 32'h0 : exp_rd;
        e.err       = exp_err;
        e.add       = addr[3:2];
        e.wrn       = !wr;
        e.data      = wdata;
        e.local_acc = addr[4];
        e.lat       = exp_lat;
        if (!start_now) repeat (4) @(negedge clk_i);
        paddr_i   = addr;
        pwdata_i  = wdata;
        pwrite_i  = wr;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        sb.push_back(e);
        start    = cyc;
        waited   = 0;
        seen_req = 1'b0;
        done     = 1'b0;
        while (!done && waited < 200) begin
            @(negedge clk_i);
            penable_i = 1'b1;
            waited++;
            if (fll_req_o && !seen_req) begin
                seen_req = 1'b1;
                checks++;
                if (fll_add_o !== e.add || fll_wrn_o !== e.wrn || fll_data_o !== e.data) begin
                    errors++;
                    $display("FAIL fll_fields addr=%h: add=%0d wrn=%b data=%h, required add=%0d wrn=%b data=%h",
                             addr, fll_add_o, fll_wrn_o, fll_data_o, e.add, e.wrn, e.data);
                end
            end
            if (pready_o) done = 1'b1;
        end
        if (!done) begin
            errors++;
            $display("FAIL pready_timeout addr=%h: no pready within 200 cycles", addr);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            checks++;
            if (prdata_o !== got.rdata || pslverr_o !== got.err) begin
                errors++;
                $display("FAIL response addr=%h: prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         addr, prdata_o, pslverr_o, got.rdata, got.err);
            end
            checks++;
            if (fll_req_o !== 1'b0) begin
                errors++;
                $display("FAIL req_in_done addr=%h: req=%b, required 0", addr, fll_req_o);
            end
            checks++;
            if (seen_req === got.local_acc) begin
                errors++;
                $display("FAIL req_seen addr=%h: req seen=%b, required %b", addr, seen_req, !got.local_acc);
            end
            if (got.lat >= 0) begin
                checks++;
                if (cyc - start != got.lat) begin
                    errors++;
                    $display("FAIL latency addr=%h: %0d cycles, required %0d", addr, cyc - start, got.lat);
                end
            end
            if (!keep_sel) begin
                psel_i    = 1'b0;
                penable_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b1;
        #1 rstn_i = 1'b0;
        #10;
        checks++;
        if (fll_req_o !== 1'b0 || fll_wrn_o !== 1'b1 || fll_add_o !== 2'd0 || fll_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_fll: req=%b wrn=%b add=%0d data=%h, required 0 1 0 0",
                     fll_req_o, fll_wrn_o, fll_add_o, fll_data_o);
        end
        checks++;
        if (pready_o !== 1'b0 || pslverr_o !== 1'b0 || prdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: pready=%b pslverr=%b prdata=%h, required 0 0 0",
                     pready_o, pslverr_o, prdata_o);
        end
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_write();
        resp_mode = 0;
        apb_xfer(12'h004, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2 + SYNC_LAT, 1'b0, 1'b0);
    endtask

    task automatic test_read_delayed();
        resp_mode    = 1;
        resp_delay   = 5;
        fll_r_data_i = 32'h12345678;
        mon_en       = 1'b1;
        apb_xfer(12'h00C, 32'h0, 1'b0, 32'h12345678, 1'b0, -1, 1'b0, 1'b0);
        mon_en = 1'b0;
    endtask

    task automatic test_timeout();
        resp_mode = 2;
        apb_xfer(12'h004, 32'h000000AA, 1'b1, 32'h0, 1'b1, TO + 1, 1'b0, 1'b0);
        apb_xfer(12'h010, 32'h0, 1'b0, 32'h2, 1'b0, 1, 1'b0, 1'b0);
        apb_xfer(12'h010, 32'h2, 1'b1, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        apb_xfer(12'h010, 32'h0, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_lock();
        fll_lock_i = 1'b1;
        repeat (4) @(negedge clk_i);
        apb_xfer(12'h010, 32'h0, 1'b0, 32'h1, 1'b0, 1, 1'b0, 1'b0);
        fll_lock_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        resp_mode  = 1;
        resp_delay = 2;
        mon_en     = 1'b1;
        apb_xfer(12'h008, 32'h11111111, 1'b1, 32'h0, 1'b0, -1, 1'b0, 1'b1);
        apb_xfer(12'h004, 32'h22222222, 1'b1, 32'h0, 1'b0, -1, 1'b1, 1'b1);
        fll_r_data_i = 32'hA5A55A5A;
        apb_xfer(12'h000, 32'h0, 1'b0, 32'hA5A55A5A, 1'b0, -1, 1'b1, 1'b0);
        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_lost: %0d transfers outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        resp_mode = 2;
        repeat (4) @(negedge clk_i);
        paddr_i   = 12'h008;
        pwdata_i  = 32'h55AA55AA;
        pwrite_i  = 1'b1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        waited    = 0;
        while (!fll_req_o && waited < 20) begin
            @(negedge clk_i);
            penable_i = 1'b1;
            waited++;
        end
        checks++;
        if (fll_req_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_req_start: req=%b, required 1", fll_req_o);
        end
        #2 rstn_i = 1'b0;
        #1;
        checks++;
        if (fll_req_o !== 1'b0 || pready_o !== 1'b0 || fll_wrn_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: req=%b pready=%b wrn=%b, required 0 0 1", fll_req_o, pready_o, fll_wrn_o);
        end
        psel_i    = 1'b0;
        penable_i = 1'b0;
        @(negedge clk_i);
        rstn_i    = 1'b1;
        resp_mode = 0;
        apb_xfer(12'h004, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 2 + SYNC_LAT, 1'b0, 1'b0);
    endtask

    initial begin
        paddr_i      = '0;
        pwdata_i     = '0;
        pwrite_i     = 1'b0;
        psel_i       = 1'b0;
        penable_i    = 1'b0;
        fll_r_data_i = '0;
        fll_lock_i   = 1'b0;
        test_reset();
        test_write();
        test_read_delayed();
        test_timeout();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
